// File: rtl/io_user_pkg.sv
// Shared types and constants for the user I/O port: input FSM states,
// 7-segment codes (active-low, bit0=a .. bit6=g) and the double-dabble step.
package io_user_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_PRESS,
        WAIT_EDGE,
        WAIT_RELEASE
    } in_state_e;

    localparam int DIGIT_W = 7;
    localparam int DEC_MAX = 9999;

    localparam logic [DIGIT_W-1:0] SEG_BLANK = 7'h7F;
    localparam logic [DIGIT_W-1:0] SEG_DASH  = 7'h3F;

    // Indexed by digit value; entries A-F only matter for the hex display build.
    localparam logic [15:0][DIGIT_W-1:0] SEG_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    function automatic logic [DIGIT_W-1:0] seg_of(input logic [3:0] d);
        return SEG_TABLE[d];
    endfunction

    // One double-dabble iteration on {bcd[15:0], bin[13:0]}.
    function automatic logic [29:0] dabble_step(input logic [29:0] sh);
        logic [29:0] t;
        t = sh;
        for (int k = 0; k < 4; k++) begin
            if (t[14+4*k +: 4] >= 4'd5) begin
                t[14+4*k +: 4] = t[14+4*k +: 4] + 4'd3;
            end
        end
        return {t[28:0], 1'b0};
    endfunction

endpackage

// File: rtl/io_user_port_if.sv
// Bundle of CPU/board-side signals for io_user_port. master drives the
// instruction and board inputs, slave is the port itself.
interface io_user_port_if;

    logic        clk_state;
    logic        inop;
    logic        outop;
    logic        bt;
    logic [13:0] in;
    logic [31:0] dm;
    logic [31:0] du;
    logic        await;
    logic [27:0] display;

    modport master (
        output clk_state, inop, outop, bt, in, dm,
        input  du, await, display
    );

    modport slave (
        input  clk_state, inop, outop, bt, in, dm,
        output du, await, display
    );

endinterface

// File: rtl/io_debounce.sv
// Button conditioner: 2-flop synchronizer followed by a down-counting
// stability timer. press_o pulses for one cycle on a debounced 0->1 change.
module io_debounce #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 5
) (
    input  logic clk,
    input  logic rst_b,
    input  logic bt_i,
    output logic level_o,
    output logic press_o
);

    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             level_q;
    logic             press_q;
    logic [CNT_W-1:0] cnt_q;

    // Terminal count is reached on the DEBOUNCE_CYCLES-th disagreeing sample.
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            cnt_q   <= RELOAD;
        end else begin
            sync1_q <= bt_i;
            sync2_q <= sync1_q;
            press_q <= 1'b0;
            if (sync2_q == level_q) begin
                cnt_q <= RELOAD;
            end else if (cnt_q == '0) begin
                level_q <= sync2_q;
                press_q <= sync2_q;
                cnt_q   <= RELOAD;
            end else begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

    assign level_o = level_q;
    assign press_o = press_q;

endmodule

// File: rtl/io_user_port.sv
// User I/O stage: IN stalls the CPU until a debounced press, OUT drives four
// 7-segment digits. Define IO_HEX_DISPLAY_EN for a hex display instead of decimal.
//
// state        | meaning
// IDLE         | no IN pending
// WAIT_PRESS   | stalling CPU until a confirm press captures the switches
// WAIT_EDGE    | value presented on du, waiting for the CPU to retire the IN
// WAIT_RELEASE | stalling until the button is released
module io_user_port
    import io_user_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 5
) (
    input  logic            clk,
    input  logic            bt_reset,
    io_user_port_if.slave   io
);

    logic                   level;
    logic                   press;
    logic                   rise;
    logic                   latch;

    logic                   clk_state_q;
    logic                   outop_q;
    in_state_e              state_q;
    logic                   await_q;
    logic [31:0]            du_q;
    logic [4*DIGIT_W-1:0]   display_q;

`ifdef IO_HEX_DISPLAY_EN
    logic [15:0]            dm_q;
    logic [15:0]            hex_q;
    logic                   hex_pend_q;
`else
    logic [31:0]            dm_q;
    logic                   busy_q;
    logic                   dash_q;
    logic [3:0]             iter_q;
    logic [29:0]            sh_q;
`endif

    io_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_debounce (
        .clk     (clk),
        .rst_b   (bt_reset),
        .bt_i    (io.bt),
        .level_o (level),
        .press_o (press)
    );

    assign rise  = io.clk_state & ~clk_state_q;
    assign latch = rise & outop_q;

    always_ff @(posedge clk) begin
        if (!bt_reset) begin
            clk_state_q <= 1'b0;
            outop_q     <= 1'b0;
            dm_q        <= '0;
        end else begin
            clk_state_q <= io.clk_state;
            outop_q     <= io.outop;
`ifdef IO_HEX_DISPLAY_EN
            dm_q        <= io.dm[15:0];
`else
            dm_q        <= io.dm;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!bt_reset) begin
            state_q <= IDLE;
            await_q <= 1'b0;
            du_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (io.inop) begin
                        state_q <= WAIT_PRESS;
                        await_q <= 1'b1;
                    end
                end
                WAIT_PRESS: begin
                    if (press) begin
                        du_q    <= {18'b0, io.in};
                        state_q <= WAIT_EDGE;
                        await_q <= 1'b0;
                    end
                end
                WAIT_EDGE: begin
                    if (rise) begin
                        state_q <= WAIT_RELEASE;
                        await_q <= 1'b1;
                    end
                end
                WAIT_RELEASE: begin
                    if (!level) begin
                        state_q <= IDLE;
                        await_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    await_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef IO_HEX_DISPLAY_EN
    always_ff @(posedge clk) begin
        if (!bt_reset) begin
            display_q  <= {4{SEG_BLANK}};
            hex_q      <= '0;
            hex_pend_q <= 1'b0;
        end else begin
            hex_pend_q <= latch;
            if (latch) begin
                hex_q <= dm_q;
            end
            if (hex_pend_q) begin
                display_q <= {seg_of(hex_q[15:12]), seg_of(hex_q[11:8]),
                              seg_of(hex_q[7:4]),   seg_of(hex_q[3:0])};
            end
        end
    end
`else
    // A new latch simply reloads the shifter, abandoning any conversion in flight.
    always_ff @(posedge clk) begin
        if (!bt_reset) begin
            display_q <= {4{SEG_BLANK}};
            busy_q    <= 1'b0;
            dash_q    <= 1'b0;
            iter_q    <= '0;
            sh_q      <= '0;
        end else begin
            dash_q <= 1'b0;
            if (dash_q) begin
                display_q <= {4{SEG_DASH}};
            end
            if (latch) begin
                if (dm_q > 32'(DEC_MAX)) begin
                    dash_q <= 1'b1;
                    busy_q <= 1'b0;
                end else begin
                    busy_q <= 1'b1;
                    iter_q <= 4'd14;
                    sh_q   <= {16'b0, dm_q[13:0]};
                end
            end else if (busy_q) begin
                if (iter_q != 4'd0) begin
                    sh_q   <= dabble_step(sh_q);
                    iter_q <= iter_q - 4'd1;
                end else begin
                    busy_q    <= 1'b0;
                    display_q <= {seg_of(sh_q[29:26]), seg_of(sh_q[25:22]),
                                  seg_of(sh_q[21:18]), seg_of(sh_q[17:14])};
                end
            end
        end
    end
`endif

    assign io.du      = du_q;
    assign io.await   = await_q;
    assign io.display = display_q;

endmodule

// File: tb/tb_io_user_port.sv
// Self-checking bench for io_user_port: IN handshake/debounce sequences,
// table-driven and randomized OUT display checks against an arithmetic model.
module tb_io_user_port;

    logic clk = 1'b0;
    logic bt_reset;
    always #5 clk = ~clk;

    io_user_port_if ifc();

    io_user_port dut (
        .clk      (clk),
        .bt_reset (bt_reset),
        .io       (ifc.slave)
    );

    int          n_chk  = 0;
    int          n_fail = 0;
    logic [27:0] cur_disp;

    typedef struct {
        logic [31:0] dm;
        logic [27:0] exp;
    } out_vec_t;

    out_vec_t tbl[$];

    function automatic logic [6:0] seg_ref(input int d);
        case (d)
            0: return 7'h40;   1: return 7'h79;   2: return 7'h24;   3: return 7'h30;
            4: return 7'h19;   5: return 7'h12;   6: return 7'h02;   7: return 7'h78;
            8: return 7'h00;   9: return 7'h10;   10: return 7'h08;  11: return 7'h03;
            12: return 7'h46;  13: return 7'h21;  14: return 7'h06;  15: return 7'h0E;
            default: return 7'h7F;
        endcase
    endfunction

    function automatic logic [27:0] model_disp(input logic [31:0] v);
`ifdef IO_HEX_DISPLAY_EN
        return {seg_ref(int'(v[15:12])), seg_ref(int'(v[11:8])),
                seg_ref(int'(v[7:4])),   seg_ref(int'(v[3:0]))};
`else
        if (v > 32'd9999) return {4{7'h3F}};
        return {seg_ref(int'(v / 1000)), seg_ref(int'((v / 100) % 10)),
                seg_ref(int'((v / 10) % 10)), seg_ref(int'(v % 10))};
`endif
    endfunction

    function automatic int model_lat(input logic [31:0] v);
`ifdef IO_HEX_DISPLAY_EN
        return 1 + int'(v[0] & 1'b0);
`else
        return (v > 32'd9999) ? 1 : 15;
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_await(input logic val, input int max, input string name);
        int k;
        k = 0;
        while (ifc.await !== val && k < max) begin
            step();
            k++;
        end
        chk(name, {31'b0, ifc.await}, {31'b0, val});
    endtask

    task automatic steps_await(input int n, input logic val, input string name);
        for (int k = 0; k < n; k++) begin
            step();
            chk(name, {31'b0, ifc.await}, {31'b0, val});
        end
    endtask

    task automatic rise_cpu();
        ifc.clk_state = 1'b1;
        step();
        ifc.clk_state = 1'b0;
    endtask

    // Returns just after the edge on which the OUT value is latched.
    task automatic latch_out(input logic [31:0] v);
        ifc.dm        = v;
        ifc.outop     = 1'b1;
        ifc.clk_state = 1'b0;
        step();
        chk("out_pre_hold", {4'b0, ifc.display}, {4'b0, cur_disp});
        ifc.clk_state = 1'b1;
        step();
        ifc.outop     = 1'b0;
        ifc.clk_state = 1'b0;
        ifc.dm        = $urandom;
        chk("out_latch_hold", {4'b0, ifc.display}, {4'b0, cur_disp});
    endtask

    task automatic expect_update(input logic [27:0] exp, input int lat, input string name);
        for (int k = 1; k <= lat; k++) begin
            step();
            if (k < lat) chk("out_hold", {4'b0, ifc.display}, {4'b0, cur_disp});
            else         chk(name, {4'b0, ifc.display}, {4'b0, exp});
        end
        cur_disp = exp;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [13:0] r2;
        logic [31:0] v;

        ifc.clk_state = 1'b0;
        ifc.inop      = 1'b0;
        ifc.outop     = 1'b0;
        ifc.bt        = 1'b0;
        ifc.in        = '0;
        ifc.dm        = '0;
        bt_reset      = 1'b0;
        cur_disp      = 28'hFFFFFFF;

`ifdef IO_HEX_DISPLAY_EN
        tbl.push_back('{32'h0000_BEEF, {7'h03, 7'h06, 7'h06, 7'h0E}});
        tbl.push_back('{32'h0000_0000, {4{7'h40}}});
        tbl.push_back('{32'h1234_A5C9, {7'h08, 7'h12, 7'h46, 7'h10}});
        tbl.push_back('{32'h0000_7D38, {7'h78, 7'h21, 7'h30, 7'h00}});
`else
        tbl.push_back('{32'd1234,       {7'h79, 7'h24, 7'h30, 7'h19}});
        tbl.push_back('{32'd10000,      {4{7'h3F}}});
        tbl.push_back('{32'd7,          {7'h40, 7'h40, 7'h40, 7'h78}});
        tbl.push_back('{32'd0,          {4{7'h40}}});
        tbl.push_back('{32'd9999,       {4{7'h10}}});
        tbl.push_back('{32'h8000_0005,  {4{7'h3F}}});
        tbl.push_back('{32'd905,        {7'h40, 7'h10, 7'h40, 7'h12}});
        tbl.push_back('{32'd16383,      {4{7'h3F}}});
`endif

        repeat (3) step();
        chk("rst_du", ifc.du, 32'h0);
        chk("rst_await", {31'b0, ifc.await}, 32'h0);
        chk("rst_display", {4'b0, ifc.display}, 32'h0FFFFFFF);
        bt_reset = 1'b1;
        step();

        // IN with a bouncy press
        ifc.in   = 14'h1234;
        ifc.inop = 1'b1;
        step();
        chk("in_await_set", {31'b0, ifc.await}, 32'h1);
        for (int k = 0; k < 5; k++) begin
            ifc.bt = ~ifc.bt;
            step();
        end
        ifc.bt = 1'b1;
        wait_await(1'b0, 60, "in_capture_await");
        chk("in_capture_du", ifc.du, 32'h1234);
        rise_cpu();
        chk("in_rise_stall", {31'b0, ifc.await}, 32'h1);
        ifc.inop = 1'b0;
        steps_await(10, 1'b1, "in_held_stall");
        ifc.bt = 1'b0;
        wait_await(1'b0, 60, "in_release");
        steps_await(3, 1'b0, "in_idle");

        // glitches one sample short of the debounce window never capture
        ifc.in   = 14'h0ABC;
        ifc.inop = 1'b1;
        step();
        for (int g = 0; g < 3; g++) begin
            ifc.bt = 1'b1;
            steps_await(15, 1'b1, "glitch_stall");
            ifc.bt = 1'b0;
            steps_await(5, 1'b1, "glitch_stall");
        end
        chk("glitch_du", ifc.du, 32'h1234);
        ifc.bt = 1'b1;
        wait_await(1'b0, 60, "glitch_then_press");
        chk("glitch_then_du", ifc.du, 32'h0ABC);

        // back-to-back IN with the button still held
        rise_cpu();
        r2     = 14'($urandom);
        ifc.in = r2;
        steps_await(30, 1'b1, "b2b_held_stall");
        chk("b2b_held_du", ifc.du, 32'h0ABC);
        ifc.bt = 1'b0;
        repeat (40) step();
        chk("b2b_rearmed", {31'b0, ifc.await}, 32'h1);
        chk("b2b_du_kept", ifc.du, 32'h0ABC);
        ifc.bt = 1'b1;
        wait_await(1'b0, 60, "b2b_second_press");
        chk("b2b_second_du", ifc.du, {18'b0, r2});
        rise_cpu();
        ifc.inop = 1'b0;
        ifc.bt   = 1'b0;
        wait_await(1'b0, 60, "b2b_release");

        // button activity in IDLE is ignored
        ifc.in = 14'h3FFF;
        ifc.bt = 1'b1;
        steps_await(30, 1'b0, "idle_bt_ignored");
        ifc.bt = 1'b0;
        steps_await(30, 1'b0, "idle_bt_ignored");
        chk("idle_du_kept", ifc.du, {18'b0, r2});

        // OUT vectors
        foreach (tbl[i]) begin
            latch_out(tbl[i].dm);
            expect_update(tbl[i].exp, model_lat(tbl[i].dm), "out_tbl");
        end

        for (int i = 0; i < 20; i++) begin
            if ($urandom_range(0, 3) == 0) v = $urandom;
            else                           v = 32'($urandom_range(0, 12000));
            latch_out(v);
            expect_update(model_disp(v), model_lat(v), "out_rand");
        end

`ifndef IO_HEX_DISPLAY_EN
        // restart: 42 latched five edges into a conversion of 9999
        latch_out(32'd9999);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("restart_hold", {4'b0, ifc.display}, {4'b0, cur_disp});
        end
        latch_out(32'd42);
        expect_update({7'h40, 7'h40, 7'h19, 7'h24}, 15, "restart_0042");
        repeat (20) step();
        chk("restart_stable", {4'b0, ifc.display}, {4'b0, cur_disp});
`endif

        // reset mid-operation
        ifc.inop = 1'b1;
        step();
        chk("midrst_stall", {31'b0, ifc.await}, 32'h1);
        latch_out(32'd5678);
        repeat (3) step();
        bt_reset = 1'b0;
        step();
        chk("midrst_await", {31'b0, ifc.await}, 32'h0);
        chk("midrst_display", {4'b0, ifc.display}, 32'h0FFFFFFF);
        chk("midrst_du", ifc.du, 32'h0);
        bt_reset = 1'b1;
        ifc.inop = 1'b0;
        cur_disp = 28'hFFFFFFF;
        repeat (20) step();
        chk("midrst_discard", {4'b0, ifc.display}, 32'h0FFFFFFF);
        chk("midrst_idle", {31'b0, ifc.await}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
